key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50_000_000, press duration in clk cycles that classifies a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 15_000_000, maximum release-to-second-press interval for a double click (300 ms).
REQ-003 SHALL have parameter CNT_W, default 26, counter width; LONG_CYCLES and GAP_CYCLES SHALL be < 2**CNT_W and >= 2.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 n_rst  in  1  reset, synchronous and active-low.
REQ-006 key_press  in  1  one-cycle pulse from the upstream debouncer on a debounced key-down.
REQ-007 key_release  in  1  one-cycle pulse from the upstream debouncer on a debounced key-up.
REQ-008 short_evt  out  1  one-cycle pulse: single short click classified.
REQ-009 long_evt  out  1  one-cycle pulse: long press classified.
REQ-010 double_evt  out  1  one-cycle pulse: double click classified.
REQ-011 proto_err  out  1  one-cycle pulse: key_press and key_release sampled high in the same cycle.
REQ-012 busy  out  1  level, high whenever state != IDLE.

Function
REQ-013 SHALL implement a one-hot FSM with states IDLE, HELD1, WAIT2, HELD2, LONG_HELD.
REQ-014 SHALL hold one CNT_W-bit counter, cleared on every state entry, incremented by 1 each cycle in HELD1 and WAIT2, saturating (no wrap).
REQ-015 IDLE: key_press -> HELD1; key_release ignored.
REQ-016 HELD1: key_release with counter < LONG_CYCLES-1 -> WAIT2; counter == LONG_CYCLES-1 without release -> LONG_HELD and pulse long_evt, i.e. long_evt high exactly LONG_CYCLES cycles after the edge sampling key_press.
REQ-017 HELD1: key_release on the same edge the counter equals LONG_CYCLES-1 -> long_evt pulsed, next state IDLE.
REQ-018 LONG_HELD: key_release -> IDLE, no further event; no repeat events.
REQ-019 WAIT2: key_press with counter < GAP_CYCLES-1 -> HELD2; counter == GAP_CYCLES-1 without press -> IDLE and pulse short_evt.
REQ-020 WAIT2: key_press on the same edge as the gap timeout -> press wins, HELD2, no short_evt.
REQ-021 HELD2: key_release -> IDLE and pulse double_evt; no timeout, no long classification in HELD2.
REQ-022 key_press in HELD1/HELD2/LONG_HELD and key_release in IDLE/WAIT2 SHALL be ignored.
REQ-023 key_press and key_release both high in one cycle: both ignored, state and counter unchanged that cycle (counter still increments if state counts), proto_err pulsed.
REQ-024 All outputs SHALL be registered; event pulses last exactly one cycle and at most one of short_evt/long_evt/double_evt is high in any cycle.

Reset
REQ-025 On the edge sampling n_rst low: state IDLE, counter 0, all outputs 0; a pending classification (e.g. in WAIT2) SHALL be discarded without any event.
REQ-026 Inputs sampled on the edge that deasserts reset SHALL be processed normally from the next edge.

Structure
REQ-027 Package key_pkg SHALL hold the one-hot state localparams and default LONG_CYCLES/GAP_CYCLES/CNT_W values shared with the debouncer.
REQ-028 Sub-module evt_timer (clear, enable, saturating count, terminal-compare input) SHALL implement the counter; FSM and output registers live in key_event_decoder.

Verification (LONG_CYCLES=10, GAP_CYCLES=5, CNT_W=8)
REQ-029 press at edge 0, release edge 3, no further press -> short_evt high only in the cycle after edge 8, busy low afterwards.
REQ-030 press edge 0, release edge 3, press edge 5, release edge 7 -> double_evt single pulse after edge 7, no short_evt.
REQ-031 press edge 0, hold -> long_evt single pulse after edge 10; release edge 20 -> no event, IDLE.
REQ-032 release on edge 10 (terminal) -> long_evt only, IDLE; press on edge 8 after release at edge 3 -> HELD2, no short_evt.
REQ-033 press and release both high at edge 2 from IDLE -> proto_err pulse, busy stays low.
REQ-034 n_rst low at edge 5 during WAIT2 -> all outputs 0, no short_evt ever emitted, next press starts fresh.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key front end: one-hot decoder states and default
// timing values, also used by the debouncer.
package key_pkg;

    localparam int DEF_LONG_CYCLES = 50_000_000;
    localparam int DEF_GAP_CYCLES  = 15_000_000;
    localparam int DEF_CNT_W       = 26;

    localparam logic [4:0] ST_IDLE      = 5'b00001;
    localparam logic [4:0] ST_HELD1     = 5'b00010;
    localparam logic [4:0] ST_WAIT2     = 5'b00100;
    localparam logic [4:0] ST_HELD2     = 5'b01000;
    localparam logic [4:0] ST_LONG_HELD = 5'b10000;

    typedef enum logic [4:0] {
        IDLE      = ST_IDLE,
        HELD1     = ST_HELD1,
        WAIT2     = ST_WAIT2,
        HELD2     = ST_HELD2,
        LONG_HELD = ST_LONG_HELD
    } key_state_e;

endpackage

// File: rtl/evt_timer.sv
// Saturating cycle counter with clear/enable and a terminal-value compare.
module evt_timer
    import key_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // >= rather than == so a terminal edge swallowed by a protocol-error cycle still fires next cycle.
    assign at_term = (cnt_q >= term);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key press/release pulses into short, long and double
// click events; all outputs are registered one-cycle pulses (busy is a level).
module key_event_decoder
    import key_pkg::*;
#(
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic n_rst,
    input  logic key_press,
    input  logic key_release,
    output logic short_evt,
    output logic long_evt,
    output logic double_evt,
    output logic proto_err,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

    key_state_e state_q, state_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic double_q, double_d;
    logic proto_q, proto_d;
    logic busy_q, busy_d;

    logic press_v, rel_v, both;
    logic tmr_clr, tmr_en, tmr_at_term;
    logic [CNT_W-1:0] tmr_term;

    assign both    = key_press & key_release;
    assign press_v = key_press & ~key_release;
    assign rel_v   = key_release & ~key_press;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        proto_d  = both;
        if (!both) begin
            unique case (state_q)
                IDLE: begin
                    if (press_v) state_d = HELD1;
                end
                HELD1: begin
                    if (tmr_at_term) begin
                        long_d  = 1'b1;
                        state_d = rel_v ? IDLE : LONG_HELD;
                    end else if (rel_v) begin
                        state_d = WAIT2;
                    end
                end
                WAIT2: begin
                    // A press on the timeout edge still counts as the second click.
                    if (press_v) begin
                        state_d = HELD2;
                    end else if (tmr_at_term) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                HELD2: begin
                    if (rel_v) begin
                        double_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                LONG_HELD: begin
                    if (rel_v) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign tmr_clr  = (state_d != state_q);
    assign tmr_en   = (state_q == HELD1) || (state_q == WAIT2);
    assign tmr_term = (state_q == WAIT2) ? GAP_TERM : LONG_TERM;

    evt_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .term    (tmr_term),
        .at_term (tmr_at_term)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            proto_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            proto_q  <= proto_d;
            busy_q   <= busy_d;
        end
    end

    assign short_evt  = short_q;
    assign long_evt   = long_q;
    assign double_evt = double_q;
    assign proto_err  = proto_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized bench for key_event_decoder against a timestamp-based reference model.
module tb_key_event_decoder;

    localparam int LONG = 10;
    localparam int GAP  = 5;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic key_press = 1'b0;
    logic key_release = 1'b0;
    logic short_evt, long_evt, double_evt, proto_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase plus the edge at which it was entered.
    int edge_n = 0;
    int mode   = 0;   // 0 idle, 1 first hold, 2 gap, 3 second hold, 4 long hold
    int since  = 0;
    logic e_short, e_long, e_double, e_proto, e_busy;

    always #5 clk = ~clk;

    key_event_decoder #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .key_press   (key_press),
        .key_release (key_release),
        .short_evt   (short_evt),
        .long_evt    (long_evt),
        .double_evt  (double_evt),
        .proto_err   (proto_err),
        .busy        (busy)
    );

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0b exp=%0b", tag, edge_n - 1, got, exp);
        end
    endtask

    task automatic enter(input int m);
        mode  = m;
        since = edge_n;
    endtask

    task automatic model_edge(input logic p, input logic r, input logic rn);
        int d;
        e_short = 0; e_long = 0; e_double = 0; e_proto = 0;
        if (!rn) begin
            mode = 0;
        end else begin
            e_proto = p & r;
            if (!(p & r)) begin
                d = edge_n - since;
                case (mode)
                    0: if (p) enter(1);
                    1: begin
                        if (d >= LONG) begin
                            e_long = 1;
                            enter(r ? 0 : 4);
                        end else if (r) begin
                            enter(2);
                        end
                    end
                    2: begin
                        if (p) enter(3);
                        else if (d >= GAP) begin
                            e_short = 1;
                            enter(0);
                        end
                    end
                    3: if (r) begin e_double = 1; enter(0); end
                    4: if (r) enter(0);
                    default: enter(0);
                endcase
            end
        end
        e_busy = (mode != 0);
        edge_n++;
    endtask

    task automatic cycle(input logic p, input logic r, input logic rn);
        @(negedge clk);
        key_press = p; key_release = r; n_rst = rn;
        @(posedge clk);
        model_edge(p, r, rn);
        #1;
        check_bit("short_evt",  short_evt,  e_short);
        check_bit("long_evt",   long_evt,   e_long);
        check_bit("double_evt", double_evt, e_double);
        check_bit("proto_err",  proto_err,  e_proto);
        check_bit("busy",       busy,       e_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    // Drives a scripted press/release sequence; edge 0 is the first cycle.
    task automatic script(input int len, input int pe[$], input int re[$]);
        for (int k = 0; k < len; k++) begin
            logic p, r;
            p = 0; r = 0;
            foreach (pe[j]) if (pe[j] == k) p = 1;
            foreach (re[j]) if (re[j] == k) r = 1;
            cycle(p, r, 1);
        end
    endtask

    initial begin
        int seen_short;
        // Reset state
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check_bit("rst_busy", busy, 1'b0);

        // Single short click
        script(12, '{0}, '{3});
        check_bit("short_done_busy", busy, 1'b0);
        // Double click
        script(12, '{0, 5}, '{3, 7});
        // Long press then late release
        script(24, '{0}, '{20});
        // Release exactly at the long terminal edge
        script(14, '{0}, '{10});
        // Second press exactly at gap timeout
        script(14, '{0, 8}, '{3, 11});
        // Simultaneous press and release from idle
        script(6, '{2}, '{2});
        check_bit("proto_busy", busy, 1'b0);
        // Reset during the gap: no short click may ever appear
        seen_short = 0;
        for (int k = 0; k < 14; k++) begin
            cycle(k == 0, k == 3, k != 5);
            if (short_evt) seen_short++;
        end
        check_bit("rst_discard_short", seen_short != 0, 1'b0);
        script(14, '{0}, '{2});

        // Random traffic with varying press/release densities
        for (int ph = 0; ph < 6; ph++) begin
            int pr;
            pr = (ph % 3 == 0) ? 4 : ((ph % 3 == 1) ? 9 : 18);
            for (int k = 0; k < 250; k++) begin
                logic p, r, rn;
                p  = ($urandom_range(pr - 1) == 0);
                r  = ($urandom_range(pr - 1) == 0);
                rn = ($urandom_range(199) != 0);
                cycle(p, r, rn);
            end
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
